pred_seq_unit: RTL and testbench



---
 rtl/pred_seq_unit_pkg.sv | 23 ++
 rtl/cla_adder_4bit.sv | 26 ++
 rtl/pred_lane_term.sv | 29 ++
 rtl/pred_seq_unit.sv | 118 +++++++++++
 tb/tb_pred_seq_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pred_seq_unit_pkg.sv
// Shared constants and state encoding for the packed-nibble reduction unit
// and the PADDSUB lane logic.
package pred_seq_unit_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned ACC_W  = 8;
  localparam int unsigned OP_W   = LANES * LANE_W;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned CNT_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Sign-extend the accumulator to the result width.
  function automatic logic [RES_W-1:0] sext_acc(input logic [ACC_W-1:0] v);
    return {{(RES_W-ACC_W){v[ACC_W-1]}}, v};
  endfunction

endpackage

// File: rtl/cla_adder_4bit.sv
// 4-bit carry-lookahead adder with carry in/out.
module cla_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/pred_lane_term.sv
// Combinational lane term: sext5(a) +/- sext5(b) in 5-bit two's complement.
module pred_lane_term
  import pred_seq_unit_pkg::*;
(
  input  logic [LANE_W-1:0] a_nib,
  input  logic [LANE_W-1:0] b_nib,
  input  logic              is_sub,
  output logic [LANE_W:0]   term
);

  logic [LANE_W-1:0] b_x;
  logic [LANE_W-1:0] sum_lo;
  logic              c4;

  // Subtraction as a + ~b + 1; since -sext5(b) == sext5(~b) + 1, the fifth bit
  // is the sign-extended bit sum a[3] ^ b_x[3] ^ carry, so 7 - (-8) = 15 fits.
  assign b_x = is_sub ? ~b_nib : b_nib;

  cla_adder_4bit u_add (
    .a    (a_nib),
    .b    (b_x),
    .cin  (is_sub),
    .sum  (sum_lo),
    .cout (c4)
  );

  assign term = {a_nib[LANE_W-1] ^ b_x[LANE_W-1] ^ c4, sum_lo};

endmodule

// File: rtl/pred_seq_unit.sv
// Multi-cycle packed-nibble reduction: one signed lane per cycle is added or
// subtracted into an 8-bit accumulator; start/busy/done handshake.
module pred_seq_unit
  import pred_seq_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_sub,
  input  logic [OP_W-1:0]  a_in,
  input  logic [OP_W-1:0]  b_in,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              last;
  logic [CNT_W-1:0]  lane_cnt;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic              sub_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [LANE_W-1:0] a_nib;
  logic [LANE_W-1:0] b_nib;
  logic [LANE_W:0]   term;
  logic              carry_mid;
  logic              carry_unused;

  assign last  = (lane_cnt == CNT_W'(LANES - 1));
  assign a_nib = a_q[{lane_cnt, 2'b00} +: LANE_W];
  assign b_nib = b_q[{lane_cnt, 2'b00} +: LANE_W];

  pred_lane_term u_lane (
    .a_nib  (a_nib),
    .b_nib  (b_nib),
    .is_sub (sub_q),
    .term   (term)
  );

  // Accumulator adder: low nibble takes the term, high nibble its sign.
  cla_adder_4bit u_acc_lo (
    .a    (acc[3:0]),
    .b    (term[3:0]),
    .cin  (1'b0),
    .sum  (acc_sum[3:0]),
    .cout (carry_mid)
  );

  cla_adder_4bit u_acc_hi (
    .a    (acc[7:4]),
    .b    ({4{term[LANE_W]}}),
    .cin  (carry_mid),
    .sum  (acc_sum[7:4]),
    .cout (carry_unused)
  );

  // Next-state, accept strobe and status decode from registered state.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = (state == ACCUM);
    done      = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ACCUM;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latches, lane counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      acc      <= '0;
      lane_cnt <= '0;
      result   <= '0;
    end else if (accept) begin
      a_q      <= a_in;
      b_q      <= b_in;
      sub_q    <= is_sub;
      acc      <= '0;
      lane_cnt <= '0;
    end else if (state == ACCUM) begin
      acc      <= acc_sum;
      lane_cnt <= lane_cnt + CNT_W'(1);
      // Result is captured on the edge entering DONE so it is valid with done.
      if (last) result <= sext_acc(acc_sum);
    end
  end

endmodule

// File: tb/tb_pred_seq_unit.sv
// Self-checking bench for pred_seq_unit: cycle model + directed vectors.
module tb_pred_seq_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_sub = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;

  pred_seq_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_sub (is_sub),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference reduction: plain integer sum over the four signed lanes.
  function automatic logic [15:0] ref_reduce(input logic [15:0] a, input logic [15:0] b,
                                             input logic sub);
    int s;
    logic [3:0] na;
    logic [3:0] nb;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      na = a[k*4 +: 4];
      nb = b[k*4 +: 4];
      if (sub) s = s + int'($signed(na)) - int'($signed(nb));
      else     s = s + int'($signed(na)) + int'($signed(nb));
    end
    return 16'(s);
  endfunction

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: an accepted op keeps the unit busy for 4 cycles, then done
  // for one cycle with the new result; otherwise the result is held.
  int          busy_left = 0;
  bit          m_done = 1'b0;
  bit          m_live = 1'b0;
  logic [15:0] m_result = '0;
  logic [15:0] pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      busy_left = 0;
      m_done    = 1'b0;
      m_result  = '0;
      m_live    = 1'b1;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        m_done   = 1'b1;
        m_result = pend;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        pend      = ref_reduce(a_in, b_in, is_sub);
        busy_left = 4;
      end
    end
  end

  // Every-cycle compare against the model, plus handshake invariants.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (m_live) begin
      check_int("busy", int'(busy), (busy_left > 0) ? 1 : 0);
      check_int("done", int'(done), int'(m_done));
      check16("result", result, m_result);
      check_int("busy_and_done", int'(busy & done), 0);
      check_int("done_pulse", int'(prev_done & done), 0);
      prev_done = done;
    end
  end

  // Called at a negedge where the unit can accept; returns edges to done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        output int lat, output logic [15:0] res);
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    is_sub = sub;
    @(negedge clk);
    start  = 1'b0;
    a_in   = 16'($urandom);
    b_in   = 16'($urandom);
    is_sub = 1'($urandom);
    lat = 0;
    res = 'x;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) begin
        res = result;
        break;
      end
    end
  endtask

  int          lat;
  logic [15:0] res;
  int          pulses;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rs;

  initial begin
    repeat (3) @(negedge clk);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check16("reset_result", result, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Basic add.
    run_op(16'h1111, 16'h2222, 1'b0, lat, res);
    check_int("t1_latency", lat, 4);
    check16("t1_result", res, 16'h000C);
    repeat (2) @(negedge clk);

    // Most negative sum.
    run_op(16'h8888, 16'h8888, 1'b0, lat, res);
    check_int("t2_latency", lat, 4);
    check16("t2_result", res, 16'hFFC0);
    @(negedge clk);

    // Lane term 15 must not wrap.
    run_op(16'h7777, 16'h8888, 1'b1, lat, res);
    check_int("t3_latency", lat, 4);
    check16("t3_result", res, 16'h003C);
    repeat (2) @(negedge clk);

    // start held through ACCUM with operand churn: one pulse, latched operands.
    start  = 1'b1;
    a_in   = 16'h1111;
    b_in   = 16'h2222;
    is_sub = 1'b0;
    pulses = 0;
    res    = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        res   = result;
        start = 1'b0;
      end else if (start) begin
        a_in   = 16'($urandom);
        b_in   = 16'($urandom);
        is_sub = 1'($urandom);
      end
    end
    check_int("t4_pulses", pulses, 1);
    check16("t4_result", res, 16'h000C);

    // Reset in the second ACCUM cycle discards the partial sum.
    start  = 1'b1;
    a_in   = 16'h1111;
    b_in   = 16'h2222;
    is_sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_int("t5_busy", int'(busy), 0);
    check_int("t5_done", int'(done), 0);
    check16("t5_result", result, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    run_op(16'h1111, 16'h2222, 1'b0, lat, res);
    check_int("t5_latency", lat, 4);
    check16("t5_rerun", res, 16'h000C);

    // Back-to-back start in the DONE cycle; old result held until new done.
    start  = 1'b1;
    a_in   = 16'hFFFF;
    b_in   = 16'h0000;
    is_sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check16("t6_hold", result, 16'h000C);
    check_int("t6_busy", int'(busy), 1);
    lat = 0;
    res = 'x;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) begin
        res = result;
        break;
      end
    end
    check_int("t6_latency", lat, 4);
    check16("t6_result", res, 16'hFFFC);

    // Random ops, mixing back-to-back and idle gaps.
    for (int n = 0; n < 3000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, lat, res);
      check_int("rand_latency", lat, 4);
      check16("rand_result", res, ref_reduce(ra, rb, rs));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
